reg32_piso_tx: RTL and testbench

- Parallel-in/serial-out transmitter for a 32-bit register word.
- Accepts one word on a valid/ready handshake, then shifts it out one bit per transfer on a serial valid/ready link, with a last-bit marker and a completion pulse.
- Sits between a 32-bit storage register and a serial consumer (the serial-to-parallel receiver side).

---
 rtl/reg32_piso_tx.sv | 92 +++++++++
 tb/tb_reg32_piso_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg32_piso_tx.sv
// Parallel-in/serial-out word transmitter: the first bit appears one cycle after d_valid && d_ready, then one bit per ser_valid && ser_ready.
// ser_ready low holds the current bit, and d_ready stays low while a word is in flight.
module reg32_piso_tx #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             done_q, done_d;
    logic             head_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    assign head_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        d_ready   = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                d_ready = !rst;
                if (d_valid && d_ready) begin
                    shreg_d   = d_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_out   = head_bit;
                ser_last  = (bit_cnt_q == LAST_CNT);
                if (ser_ready) begin
                    // Shift the sent bit out so the next one sits at the output end.
                    shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg_q[WIDTH-1:1]};
                    if (ser_last) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_reg32_piso_tx.sv
// Bench for reg32_piso_tx: vector table, directed frame sequences and random traffic against a bit-index reference model.
module tb_reg32_piso_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_in = '0;
    logic        d_valid = 1'b0;
    logic        ser_ready = 1'b0;
    logic        d_ready, ser_out, ser_valid, ser_last, busy, done;

    logic [31:0] b_d_in = '0;
    logic        b_d_valid = 1'b0;
    logic        b_ser_ready = 1'b0;
    logic        b_d_ready, b_ser_out, b_ser_valid, b_ser_last, b_busy, b_done;

    int errors = 0;
    int checks = 0;

    // Reference model: a word in flight and the index of the next bit to send.
    bit          m_busy = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_word = '0;
    bit          m_done = 1'b0;

    logic [31:0] rx_word = '0;
    int          rx_cnt = 0;
    logic [31:0] last_rx = '0;

    logic obs_rdy, obs_vld, obs_out, obs_last, obs_busy, obs_done;

    always #5 clk = ~clk;

    reg32_piso_tx #(.WIDTH(32), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_last(ser_last), .busy(busy), .done(done)
    );

    reg32_piso_tx #(.WIDTH(32), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .d_in(b_d_in), .d_valid(b_d_valid), .d_ready(b_d_ready),
        .ser_out(b_ser_out), .ser_valid(b_ser_valid), .ser_ready(b_ser_ready),
        .ser_last(b_ser_last), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the MSB-first instance: drive, sample mid-cycle, compare with model, advance.
    task automatic cyc(input logic r, input logic dv, input logic [31:0] di, input logic sr);
        logic e_out;
        rst = r; d_valid = dv; d_in = di; ser_ready = sr;
        @(negedge clk);
        obs_rdy = d_ready; obs_vld = ser_valid; obs_out = ser_out;
        obs_last = ser_last; obs_busy = busy; obs_done = done;
        e_out = m_busy ? m_word[31 - m_idx] : 1'b0;
        chk("d_ready", {31'd0, obs_rdy}, {31'd0, !r && !m_busy});
        chk("ser_valid", {31'd0, obs_vld}, {31'd0, m_busy});
        chk("ser_out", {31'd0, obs_out}, {31'd0, e_out});
        chk("ser_last", {31'd0, obs_last}, {31'd0, m_busy && m_idx == 31});
        chk("busy", {31'd0, obs_busy}, {31'd0, m_busy});
        chk("done", {31'd0, obs_done}, {31'd0, m_done});
        if (r) begin
            rx_cnt = 0;
        end else if (obs_vld && sr) begin
            rx_word = {rx_word[30:0], obs_out};
            rx_cnt++;
            if (obs_last) begin
                chk("rx_word", rx_word, m_word);
                chk("rx_bits", rx_cnt, 32);
                last_rx = rx_word;
                rx_cnt = 0;
            end
        end
        if (r) begin
            m_busy = 1'b0; m_done = 1'b0;
        end else if (!m_busy && dv) begin
            m_busy = 1'b1; m_word = di; m_idx = 0; m_done = 1'b0;
        end else if (m_busy && sr) begin
            m_done = (m_idx == 31);
            if (m_idx == 31) m_busy = 1'b0;
            else m_idx++;
        end else begin
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        dv;
        logic [31:0] di;
        logic        sr;
        logic        e_rdy;
        logic        e_vld;
        logic        e_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] pat;
        logic [31:0] w;
        logic        held;

        tbl[0] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].r, tbl[i].dv, tbl[i].di, tbl[i].sr);
            chk($sformatf("tbl%0d_rdy", i), {31'd0, obs_rdy}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_vld", i), {31'd0, obs_vld}, {31'd0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_done", i), {31'd0, obs_done}, {31'd0, tbl[i].e_done});
        end

        // A5A5_A5A5 frame with a competing word offered throughout.
        pat = 32'h0000_00A5;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 32'h1234_5678, 1'b1);
            chk("a5_bit", {31'd0, obs_out}, {31'd0, pat[7 - (i % 8)]});
            chk("a5_last", {31'd0, obs_last}, {31'd0, i == 31});
            chk("a5_rdy", {31'd0, obs_rdy}, 32'd0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("a5_done", {31'd0, obs_done}, 32'd1);
        chk("a5_done_rdy", {31'd0, obs_rdy}, 32'd1);
        chk("a5_word", last_rx, 32'hA5A5_A5A5);

        // DEAD_BEEF with a 3-cycle stall after bit 10.
        w = 32'hDEAD_BEEF;
        cyc(1'b0, 1'b1, w, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        held = w[21];
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
            chk("stall_out", {31'd0, obs_out}, {31'd0, held});
            chk("stall_last", {31'd0, obs_last}, 32'd0);
        end
        for (int i = 0; i < 22; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("beef_done", {31'd0, obs_done}, 32'd1);
        chk("beef_word", last_rx, 32'hDEAD_BEEF);

        // Reset after 16 bits, then a clean frame.
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h5555_5555, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("abort_vld", {31'd0, obs_vld}, 32'd0);
        chk("abort_done", {31'd0, obs_done}, 32'd0);
        cyc(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1);
        chk("abort_done2", {31'd0, obs_done}, 32'd0);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("eeee_done", {31'd0, obs_done}, 32'd1);
        chk("eeee_word", last_rx, 32'hEEEE_EEEE);

        // LSB-first instance, word 1.
        b_d_valid = 1'b1; b_d_in = 32'h0000_0001; b_ser_ready = 1'b1;
        @(negedge clk);
        chk("lsb_rdy", {31'd0, b_d_ready}, 32'd1);
        @(posedge clk);
        #1;
        b_d_valid = 1'b0; b_d_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("lsb_vld", {31'd0, b_ser_valid}, 32'd1);
            chk("lsb_bit", {31'd0, b_ser_out}, {31'd0, i == 0});
            chk("lsb_last", {31'd0, b_ser_last}, {31'd0, i == 31});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("lsb_done", {31'd0, b_done}, 32'd1);
        chk("lsb_vld_end", {31'd0, b_ser_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Random traffic, stalls, noise on d_valid/d_in and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom,
                $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
